// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int unsigned MaxBurstDefault = 4;
   localparam int unsigned CntW            = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: the lone requester wins, a tie goes to the port not served last.
module mem_arbiter_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic pick_o
);

   always_comb begin
      if (req0_i && req1_i) begin
         pick_o = (last_i == PORT0) ? PORT1 : PORT0;
      end else begin
         pick_o = req1_i ? PORT1 : PORT0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto one shared memory, with a bounded burst per owner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = MaxBurstDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] adr0,
   input  logic [31:0] adr1,
   input  logic [31:0] wd0,
   input  logic [31:0] wd1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [31:0] rd0,
   output logic [31:0] rd1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       rd0_q, rd0_d, rd1_q, rd1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

   logic              busy, req_own, req_oth, we_own, xfer, burst_done, pick;
   logic [CntW-1:0]   cnt_inc;

   assign busy    = (state_q == StBusy);
   assign req_own = (owner_q == PORT1) ? req1 : req0;
   assign req_oth = (owner_q == PORT1) ? req0 : req1;
   assign we_own  = (owner_q == PORT1) ? we1  : we0;
   assign xfer    = busy & req_own;

   // Saturate so a long solo burst still yields as soon as the other port asks.
   assign cnt_inc    = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 1'b1;
   assign burst_done = xfer & (cnt_inc == MaxCnt);

   mem_arbiter_rr_pick u_rr_pick (
      .req0_i (req0),
      .req1_i (req1),
      .last_i (last_q),
      .pick_o (pick)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d = StBusy;
               owner_d = pick;
               cnt_d   = '0;
            end
         end
         StBusy: begin
            if (!req_own || (burst_done && req_oth)) begin
               last_d = owner_q;
               cnt_d  = '0;
               if (req_oth) begin
                  owner_d = ~owner_q;
               end else begin
                  state_d = StIdle;
               end
            end else if (xfer) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rvalid0_d = xfer & ~we_own & (owner_q == PORT0);
      rvalid1_d = xfer & ~we_own & (owner_q == PORT1);
      rd0_d     = rvalid0_d ? mem_rd : rd0_q;
      rd1_d     = rvalid1_d ? mem_rd : rd1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= PORT0;
         last_q    <= PORT1;
         cnt_q     <= '0;
         rd0_q     <= '0;
         rd1_q     <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   assign gnt0    = busy & (owner_q == PORT0);
   assign gnt1    = busy & (owner_q == PORT1);
   assign rd0     = rd0_q;
   assign rd1     = rd1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign mem_we  = xfer & we_own & ~reset;
   assign mem_a   = busy ? ((owner_q == PORT1) ? adr1 : adr0) : 32'h0;
   assign mem_wd  = busy ? ((owner_q == PORT1) ? wd1 : wd0) : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] adr0, adr1, wd0, wd1;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;
   logic        mem_init;
   logic [31:0] mem [0:63];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_BURST(4)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .adr0    (adr0),
      .adr1    (adr1),
      .wd0     (wd0),
      .wd1     (wd1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .rd0     (rd0),
      .rd1     (rd1),
      .rvalid0 (rvalid0),
      .rvalid1 (rvalid1),
      .mem_we  (mem_we),
      .mem_a   (mem_a),
      .mem_wd  (mem_wd),
      .mem_rd  (mem_rd)
   );

   assign mem_rd = mem[mem_a[7:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4] <= 32'hDEAD_BEEF;
         mem[5] <= 32'hA5A5_0001;
      end else if (mem_we) begin
         mem[mem_a[7:2]] <= mem_wd;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n0;
      reset = 1'b1; mem_init = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
      tick();
      mem_init = 1'b0;
      tick();
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_rvalid0", 32'(rvalid0), 32'd0);
      check("rst_rvalid1", 32'(rvalid1), 32'd0);
      check("rst_rd0", rd0, 32'h0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_mem_a", mem_a, 32'h0);

      // Single read on port 0
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; adr0 = 32'h10;
      tick();
      check("rd_gnt0", 32'(gnt0), 32'd1);
      check("rd_gnt1", 32'(gnt1), 32'd0);
      check("rd_mem_a", mem_a, 32'h10);
      check("rd_mem_we", 32'(mem_we), 32'd0);
      tick();
      check("rd_rvalid0", 32'(rvalid0), 32'd1);
      check("rd_data0", rd0, 32'hDEAD_BEEF);
      req0 = 1'b0;
      tick();
      check("rd_rvalid0_pulse", 32'(rvalid0), 32'd0);
      check("rd_release", 32'(gnt0), 32'd0);
      check("rd_hold0", rd0, 32'hDEAD_BEEF);

      // Tie after port 0 was last served goes to port 1
      req0 = 1'b1; req1 = 1'b1; adr1 = 32'h14; we1 = 1'b0;
      tick();
      check("tie_gnt1", 32'(gnt1), 32'd1);
      check("tie_gnt0", 32'(gnt0), 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("tie_idle", 32'(gnt1), 32'd0);

      // Simultaneous requests after reset, handover without idle cycle
      do_reset();
      req0 = 1'b1; adr0 = 32'h10; req1 = 1'b1; adr1 = 32'h14;
      tick();
      check("sim_gnt0", 32'(gnt0), 32'd1);
      check("sim_gnt1_low", 32'(gnt1), 32'd0);
      tick();
      check("sim_rvalid0", 32'(rvalid0), 32'd1);
      req0 = 1'b0;
      tick();
      check("sim_gnt1", 32'(gnt1), 32'd1);
      check("sim_gnt0_low", 32'(gnt0), 32'd0);
      tick();
      check("sim_rvalid1", 32'(rvalid1), 32'd1);
      check("sim_rd1", rd1, 32'hA5A5_0001);
      req1 = 1'b0;
      tick();
      check("sim_idle", 32'(gnt1), 32'd0);

      // Burst limit with contention
      do_reset();
      req0 = 1'b1; adr0 = 32'h10;
      tick();
      req1 = 1'b1; adr1 = 32'h14;
      n0 = 0;
      for (int i = 0; i < 20 && !gnt1; i++) begin
         if (gnt0 && req0) n0++;
         tick();
      end
      check("burst_len", 32'(n0), 32'd4);
      check("burst_gnt1", 32'(gnt1), 32'd1);
      check("burst_gnt0_low", 32'(gnt0), 32'd0);
      tick();
      req1 = 1'b0;
      tick();
      check("regrant_gnt0", 32'(gnt0), 32'd1);
      check("regrant_gnt1", 32'(gnt1), 32'd0);
      req0 = 1'b0;
      tick();

      // Write on port 1 then read back on port 0
      do_reset();
      req1 = 1'b1; we1 = 1'b1; adr1 = 32'h20; wd1 = 32'h1234_5678;
      tick();
      check("wr_gnt1", 32'(gnt1), 32'd1);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_a", mem_a, 32'h20);
      check("wr_mem_wd", mem_wd, 32'h1234_5678);
      tick();
      req1 = 1'b0; we1 = 1'b0;
      #1;
      check("wr_we_one_cycle", 32'(mem_we), 32'd0);
      check("wr_gnt1_idle_req", 32'(gnt1), 32'd1);
      check("wr_no_rvalid", 32'(rvalid1), 32'd0);
      req0 = 1'b1; we0 = 1'b0; adr0 = 32'h20;
      tick();
      check("rb_gnt0", 32'(gnt0), 32'd1);
      check("rb_mem_we", 32'(mem_we), 32'd0);
      tick();
      check("rb_rvalid0", 32'(rvalid0), 32'd1);
      check("rb_rd0", rd0, 32'h1234_5678);
      req0 = 1'b0;
      tick();

      // Long solo burst, then saturated counter yields at the next transfer
      do_reset();
      req0 = 1'b1; adr0 = 32'h10;
      tick();
      n0 = 0;
      for (int i = 0; i < 10; i++) begin
         check("solo_gnt0", 32'(gnt0), 32'd1);
         if (gnt0 && req0) n0++;
         tick();
      end
      check("solo_count", 32'(n0), 32'd10);
      req1 = 1'b1; adr1 = 32'h14;
      tick();
      check("sat_release", 32'(gnt1), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // Reset during a port-1 read transfer
      do_reset();
      req1 = 1'b1; adr1 = 32'h14;
      tick();
      check("mid_gnt1", 32'(gnt1), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_gnt1", 32'(gnt1), 32'd0);
      check("mid_rst_gnt0", 32'(gnt0), 32'd0);
      check("mid_rst_rvalid1", 32'(rvalid1), 32'd0);
      check("mid_rst_rd1", rd1, 32'h0);
      req1 = 1'b0;
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; adr0 = 32'h24; wd0 = 32'hCAFE_F00D;
      tick();
      check("rw_mem_we", 32'(mem_we), 32'd1);
      reset = 1'b1;
      #1;
      check("rw_we_in_reset", 32'(mem_we), 32'd0);
      tick();
      check("rw_rst_gnt0", 32'(gnt0), 32'd0);
      check("rw_no_commit", mem[9], 32'h0);
      reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: max consecutive transfers for one owner while the other port waits (legal range 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0/req1  in  1  port request, held with its command until granted.
REQ-005 we0/we1  in  1  port write enable (1 = write, 0 = read).
REQ-006 adr0/adr1  in  32  port byte address.
REQ-007 wd0/wd1  in  32  port write data.
REQ-008 gnt0/gnt1  out  1  registered grant; at most one high.
REQ-009 rd0/rd1  out  32  registered read data.
REQ-010 rvalid0/rvalid1  out  1  one-cycle pulse: rdN valid.
REQ-011 mem_we  out  1  write strobe to shared memory.
REQ-012 mem_a  out  32  address to shared memory.
REQ-013 mem_wd  out  32  write data to shared memory.
REQ-014 mem_rd  in  32  combinational read data from shared memory.

Function
REQ-015 FSM states: IDLE (no owner), BUSY (owner = port 0 or 1); the state, owner, last-served pointer and burst counter are registered.
REQ-016 IDLE, any req at edge: BUSY; owner = the requester, or if both request, the port != last-served; gnt_owner high from next cycle.
REQ-017 A transfer occurs in each cycle with gnt_owner=1 and req_owner=1; the burst counter increments on each transfer.
REQ-018 mem_a/mem_wd = owner's adr/wd combinationally while BUSY, else 0; mem_we = gnt_owner & req_owner & we_owner.
REQ-019 Write commits at the edge ending the transfer cycle; no rvalid for writes.
REQ-020 Read: mem_rd captured into rd_owner at transfer edge; rvalid_owner high exactly the next cycle; rdN holds value until next read on port N.
REQ-021 BUSY release at edge when req_owner=0, or transfer brings counter to MAX_BURST while other req=1.
REQ-022 On release: other req=1 -> owner = other, counter = 0, stay BUSY (grant switches with no idle cycle); else IDLE; last-served = old owner.
REQ-023 Counter at MAX_BURST with other req=0: owner keeps grant, counter saturates.
REQ-024 gnt0 & gnt1 never both 1; grants change only at clock edges.
REQ-025 Cycle with gnt_owner=1, req_owner=0: no transfer, mem_we=0.
REQ-026 Starvation bound: a held request is granted within MAX_BURST+1 cycles.

Reset
REQ-027 reset=1 at edge: IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rd0=rd1=0, counter=0, last-served=1 (port 0 wins first tie).
REQ-028 Reset mid-transfer: in-flight read rvalid suppressed; mem_we=0 during any reset cycle.

Structure
REQ-029 Shared package holds FSM state encoding (IDLE, BUSY), port index constants PORT0/PORT1, MAX_BURST default.
REQ-030 One sub-module natural: rr_pick (combinational 2-way round-robin selector from req0, req1, last-served).

Verification
REQ-031 Reset then req0 read adr0=0x10, mem[4]=0xDEADBEEF -> gnt0 next cycle, rd0=0xDEADBEEF with rvalid0 one cycle after transfer.
REQ-032 Simultaneous req0,req1 after reset -> port 0 granted first; after port 0 drops req, gnt1 next cycle with no idle cycle.
REQ-033 MAX_BURST=4, req0 held continuous, req1 raised -> 4 port-0 transfers, then gnt1; port 0 re-granted after port 1 releases.
REQ-034 req1 write adr1=0x20 wd1=0x12345678, then req0 read 0x20 -> rd0=0x12345678; mem_we high exactly one cycle.
REQ-035 Port 0 alone held 10 cycles -> 10 consecutive transfers, gnt0 never drops, counter saturates.
REQ-036 reset asserted during port-1 read transfer -> next cycle gnt1=0, rvalid1=0, rd1=0, state IDLE.
